uart_rx_stream: RTL and testbench
=================================

Name: uart_rx_stream

Overview:
- Serial receive front end that feeds the BIOS command dispatcher.
- Converts the asynchronous UART RX line (8N1, LSB first) into an AXI-stream-style byte stream: o_data, o_valid, i_ready.
- Includes a small first-word-fall-through (FWFT) FIFO so bytes are not lost while the dispatcher is busy or held off by clk_en.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- DIVISOR, 868: clk cycles per UART bit (100 MHz / 115200); legal range 8..65535.
- FIFO_DEPTH, 16: byte entries in the output FIFO; power of two, 2..256.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- i_rx  input  1  asynchronous UART line; idles high
- o_data  output  8  FIFO head byte; valid only while o_valid=1
- o_valid  output  1  FIFO non-empty
- i_ready  input  1  consumer accepts head byte; pop occurs when o_valid & i_ready
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low
- o_overrun  output  1  one-cycle pulse: completed byte dropped because FIFO full
- o_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset:
  - Synchronous, active-high, on clk.
  - Sets o_valid=0, o_count=0, o_frame_err=0, o_overrun=0, o_data=0, FSM=IDLE, and synchronizer flops=1.
  - FIFO contents are discarded.
  - Reset mid-frame abandons the frame; reception restarts at the next falling edge seen after reset release.
- Input synchronizer:
  - i_rx passes through 2 flops; rx_s is the second flop's output.
  - Edge detection uses rx_s and one further delayed copy.
- Bit timer: down-counter of width $clog2(DIVISOR). A "tick" is the cycle in which the counter equals 0.
- FSM, all transitions on clk:
  - IDLE: on a falling edge of rx_s, load timer=DIVISOR/2-1 (integer divide) and go to START.
  - START: on tick, sample rx_s.
    - rx_s=0: load timer=DIVISOR-1, set bit_idx=0, go to DATA.
    - rx_s=1: treat as glitch, go to IDLE with no flags.
  - DATA: on tick, shift rx_s into shift[7] and right-shift the register (LSB first), then reload timer=DIVISOR-1.
    - After the 8th sample (bit_idx=7), go to STOP.
  - STOP: on tick, sample rx_s.
    - rx_s=1: issue push request, go to IDLE.
    - rx_s=0: pulse o_frame_err the next cycle, discard the byte, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. A held-low line (break) produces exactly one o_frame_err.
  - Any illegal state goes to IDLE.
- Sample timing: each sample falls at the nominal bit centre ±1 cycle.
- Latency: stop-bit sample cycle N gives o_valid=1 (from empty) and o_data=byte in cycle N+1.
- FIFO:
  - FWFT: o_data always shows the head entry.
  - o_count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
  - Push is accepted if o_count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped, o_overrun pulses in cycle N+1, and FIFO contents are unchanged.
  - Pop when empty is ignored (o_valid=0).
  - Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - o_data and o_valid are stable while o_valid & ~i_ready.
- Back-to-back frames: a falling edge arriving directly after the stop-bit sample is detected normally; IDLE is re-entered in the same cycle the push is issued.
- o_frame_err and o_overrun are mutually exclusive per frame and never assert for more than one cycle per frame.

Test Plan:
- DIVISOR=16, FIFO_DEPTH=4, i_ready=1; send 0x01 -> o_valid high for 1 cycle with o_data=0x01, 1 cycle after the stop-bit centre; o_count returns to 0.
- i_ready=0; send 0xA5, 0x3C, 0x07 back-to-back -> o_count=3; raise i_ready -> bytes pop in order A5, 3C, 07, one per cycle; o_valid then drops.
- i_ready=0; send 5 bytes 0x10..0x14 -> o_count saturates at 4; one o_overrun pulse on the 5th byte; drain returns 0x10..0x13.
- Frame 0x55 with stop bit driven low -> one o_frame_err pulse, no push; line held low 40 bit-times -> no further pulses; a following 0x0B is received correctly.
- Low glitch of 3 cycles on an idle line -> FSM returns to IDLE, no push, no flags; a subsequent 0x0C is received correctly.
- Assert rst for 1 cycle during the DATA bits of 0xFF -> outputs at reset values, no push, no flags; next frame 0x02 is received correctly.

Source files
------------

// File: rtl/uart_rx_stream.sv
// UART 8N1 receiver feeding a small first-word-fall-through byte FIFO with a valid/ready output.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_stream #(
  parameter int DIVISOR    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_rx,
  output logic [7:0]                        o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic                              o_frame_err,
  output logic                              o_overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
  output logic [2:0]                        o_dbg_state
);

  localparam int TW = $clog2(DIVISOR);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(DIVISOR / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(DIVISOR - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q;
  logic            sync1_q, rx_s_q, rx_prev_q;
  logic            fall, tick, push_req;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            pop, push, full;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= i_rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall = rx_prev_q & ~rx_s_q;
  assign tick = (timer_q == '0);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_req    = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          timer_d = HALF_LOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rx_s_q) begin
            timer_d   = FULL_LOAD;
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          timer_d   = FULL_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (rx_s_q) begin
            push_req = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_BREAK: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= push_req & full & ~pop;
    end
  end

  // Valid/ready: a byte transfers in every cycle where o_valid & i_ready are both high;
  // o_valid never drops and o_data never changes while a byte waits unaccepted.
  assign pop  = o_valid & i_ready;
  assign full = (count_q == CW'(FIFO_DEPTH));
  assign push = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= shift_q;
  end

  assign o_valid     = (count_q != '0);
  assign o_data      = o_valid ? mem[rd_ptr_q] : 8'h00;
  assign o_count     = count_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Bench for uart_rx_stream at DIVISOR=16, FIFO_DEPTH=4: serial frames are driven bit by bit,
// expected bytes go into exp_q when a frame starts and are popped as the DUT hands them out.
module tb_uart_rx_stream;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_rx;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic [2:0] o_count;
  logic [2:0] o_dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int exp_ovr, exp_fe;
  int pop_cnt, fe_cnt, ovr_cnt, first_pop_k, last_pop_k;

  uart_rx_stream #(.DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun),
    .o_count(o_count), .o_dbg_state(o_dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    i_rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok);
    if (stop_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovr++;
    end else begin
      exp_fe++;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_ok);
  endtask

  // Scoreboard: compares every accepted byte against the head of exp_q and tallies pulses.
  task automatic scoreboard_watch(input int ncyc);
    logic [7:0] e;
    pop_cnt = 0; fe_cnt = 0; ovr_cnt = 0; first_pop_k = -1; last_pop_k = -1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (o_frame_err) fe_cnt++;
      if (o_overrun) ovr_cnt++;
      if (o_valid && i_ready) begin
        pop_cnt++;
        if (first_pop_k < 0) first_pop_k = k;
        last_pop_k = k;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got byte %02h, none expected", o_data);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e) begin
            errors++;
            $display("FAIL pop_data: got %02h expected %02h", o_data, e);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_rx = 1'b1; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_valid, o_count} !== 4'b0000) begin
      errors++; $display("FAIL reset_valid_count: got %b/%0d expected 0/0", o_valid, o_count);
    end
    checks++;
    if ({o_frame_err, o_overrun} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b%b expected 00", o_frame_err, o_overrun);
    end
    checks++;
    if (o_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %02h expected 00", o_data);
    end
    checks++;
    if (o_dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", o_dbg_state, ST_IDLE);
    end
    align();
    rst = 1'b0;
  endtask

  task automatic test_single();
    i_ready = 1'b1; exp_fe = 0; exp_ovr = 0;
    align();
    fork
      send_byte(8'h01, 1'b1);
      scoreboard_watch(200);
    join
    checks++;
    if (pop_cnt != 1) begin
      errors++; $display("FAIL single_pops: got %0d expected 1", pop_cnt);
    end
    checks++;
    if (first_pop_k != 155) begin
      errors++; $display("FAIL single_latency: got cycle %0d expected 155", first_pop_k);
    end
    checks++;
    if (fe_cnt != exp_fe || ovr_cnt != exp_ovr) begin
      errors++; $display("FAIL single_flags: got fe %0d ovr %0d expected %0d %0d", fe_cnt, ovr_cnt, exp_fe, exp_ovr);
    end
    checks++;
    if (o_count !== 3'd0) begin
      errors++; $display("FAIL single_count: got %0d expected 0", o_count);
    end
  endtask

  task automatic drain(input string name, input int n);
    align();
    i_ready = 1'b1;
    scoreboard_watch(n + 6);
    checks++;
    if (pop_cnt != n || first_pop_k != 0 || last_pop_k != n - 1) begin
      errors++;
      $display("FAIL %s_drain: got %0d pops at %0d..%0d expected %0d at 0..%0d", name, pop_cnt, first_pop_k, last_pop_k, n, n - 1);
    end
    checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0) begin
      errors++; $display("FAIL %s_empty: got valid %b count %0d expected 0 0", name, o_valid, o_count);
    end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b0; exp_fe = 0; exp_ovr = 0;
    align();
    fork
      begin
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h07, 1'b1);
      end
      scoreboard_watch(3 * 160 + 10);
    join
    checks++;
    if (o_count !== 3'd3 || o_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_count: got %0d valid %b expected 3 1", o_count, o_valid);
    end
    checks++;
    if (o_data !== exp_q[0]) begin
      errors++; $display("FAIL b2b_head: got %02h expected %02h", o_data, exp_q[0]);
    end
    checks++;
    if (pop_cnt != 0 || fe_cnt != exp_fe || ovr_cnt != exp_ovr) begin
      errors++; $display("FAIL b2b_flags: got pops %0d fe %0d ovr %0d expected 0 %0d %0d", pop_cnt, fe_cnt, ovr_cnt, exp_fe, exp_ovr);
    end
    drain("b2b", 3);
  endtask

  task automatic test_overrun();
    i_ready = 1'b0; exp_fe = 0; exp_ovr = 0;
    align();
    fork
      for (int b = 0; b < 5; b++) send_byte(8'h10 + 8'(b), 1'b1);
      scoreboard_watch(5 * 160 + 10);
    join
    checks++;
    if (ovr_cnt != exp_ovr || fe_cnt != exp_fe) begin
      errors++; $display("FAIL ovr_pulses: got ovr %0d fe %0d expected %0d %0d", ovr_cnt, fe_cnt, exp_ovr, exp_fe);
    end
    checks++;
    if (o_count !== 3'(DEPTH)) begin
      errors++; $display("FAIL ovr_count: got %0d expected %0d", o_count, DEPTH);
    end
    drain("ovr", DEPTH);
  endtask

  task automatic test_frame_err();
    i_ready = 1'b1; exp_fe = 0; exp_ovr = 0;
    align();
    fork
      begin
        send_byte(8'h55, 1'b0);
        repeat (40) drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
      end
      scoreboard_watch(830);
    join
    checks++;
    if (fe_cnt != exp_fe || ovr_cnt != 0 || pop_cnt != 0) begin
      errors++; $display("FAIL ferr_pulses: got fe %0d ovr %0d pops %0d expected %0d 0 0", fe_cnt, ovr_cnt, pop_cnt, exp_fe);
    end
    align();
    fork
      send_byte(8'h0B, 1'b1);
      scoreboard_watch(200);
    join
    checks++;
    if (pop_cnt != 1 || fe_cnt != 0) begin
      errors++; $display("FAIL ferr_recover: got pops %0d fe %0d expected 1 0", pop_cnt, fe_cnt);
    end
  endtask

  task automatic test_glitch();
    i_ready = 1'b1;
    align();
    fork
      begin
        i_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_rx = 1'b1;
      end
      scoreboard_watch(40);
    join
    checks++;
    if (o_dbg_state !== ST_IDLE || pop_cnt != 0 || fe_cnt != 0 || ovr_cnt != 0) begin
      errors++; $display("FAIL glitch: got state %0d pops %0d fe %0d ovr %0d expected %0d 0 0 0", o_dbg_state, pop_cnt, fe_cnt, ovr_cnt, ST_IDLE);
    end
    align();
    fork
      send_byte(8'h0C, 1'b1);
      scoreboard_watch(200);
    join
    checks++;
    if (pop_cnt != 1) begin
      errors++; $display("FAIL glitch_recover: got pops %0d expected 1", pop_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    i_ready = 1'b1;
    align();
    fork
      begin
        drive_bit(1'b0);
        repeat (3) drive_bit(1'b1);
      end
      scoreboard_watch(60);
    join
    checks++;
    if (o_dbg_state !== ST_DATA) begin
      errors++; $display("FAIL midrst_pre_state: got %0d expected %0d", o_dbg_state, ST_DATA);
    end
    rst = 1'b1;
    align();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_valid, o_count, o_frame_err, o_overrun, o_data, o_dbg_state} !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_outputs: got v%b c%0d fe%b ov%b d%02h s%0d expected all 0", o_valid, o_count, o_frame_err, o_overrun, o_data, o_dbg_state);
    end
    fork
      repeat (6) drive_bit(1'b1);
      scoreboard_watch(100);
    join
    checks++;
    if (pop_cnt != 0 || fe_cnt != 0 || ovr_cnt != 0) begin
      errors++; $display("FAIL midrst_quiet: got pops %0d fe %0d ovr %0d expected 0 0 0", pop_cnt, fe_cnt, ovr_cnt);
    end
    align();
    fork
      send_byte(8'h02, 1'b1);
      scoreboard_watch(200);
    join
    checks++;
    if (pop_cnt != 1) begin
      errors++; $display("FAIL midrst_recover: got pops %0d expected 1", pop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_expected: got %0d bytes never delivered expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
